// File: rtl/stack_mem_pkg.sv
// Shared types and default stack bounds for the stack/memory access sequencer.
package stack_mem_pkg;

  localparam logic [15:0] DEFAULT_SP_TOP   = 16'hFFFF;
  localparam logic [15:0] DEFAULT_SP_LIMIT = 16'hFF00;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/stack_mem_ctrl_sp_tracker.sv
// Stack pointer register with increment/decrement enables and empty/full status.
module sp_tracker
  import stack_mem_pkg::*;
#(
  parameter logic [15:0] SP_TOP   = DEFAULT_SP_TOP,
  parameter logic [15:0] SP_LIMIT = DEFAULT_SP_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] sp,
  output logic        stack_empty,
  output logic        stack_full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_TOP;
    end else if (inc) begin
      sp <= sp + 16'd1;
    end else if (dec) begin
      sp <= sp - 16'd1;
    end
  end

  assign stack_empty = (sp == SP_TOP);
  assign stack_full  = (sp == SP_LIMIT - 16'd1);

endmodule

// File: rtl/stack_mem_ctrl.sv
// Sequences one load/store/push/pop at a time onto the data memory and owns the stack pointer.
module stack_mem_ctrl
  import stack_mem_pkg::*;
#(
  parameter logic [15:0] SP_TOP   = DEFAULT_SP_TOP,
  parameter logic [15:0] SP_LIMIT = DEFAULT_SP_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [8:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        dm_load,
  output logic        dm_store,
  output logic        dm_push,
  output logic        dm_pop,
  output logic [8:0]  dm_address,
  output logic [15:0] dm_sp,
  output logic [15:0] dm_rez,
  input  logic [15:0] dm_data_out,
  output logic [15:0] sp,
  output logic        stack_empty,
  output logic        stack_full
);

  state_e state;
  op_e    op_q;
  op_e    req_op_e;
  logic   accept;
  logic   sp_inc;
  logic   sp_dec;

  assign req_op_e  = op_e'(req_op);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // POP pre-increments at acceptance; PUSH post-decrements as its write strobe retires.
  assign sp_inc = accept && (req_op_e == OP_POP) && !stack_empty;
  assign sp_dec = (state == ISSUE) && (op_q == OP_PUSH);

  // PUSH writes at the current sp and POP reads at the already-incremented sp,
  // so the memory-side stack pointer always equals sp.
  assign dm_sp = sp;

  sp_tracker #(
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_tracker (
    .clk         (clk),
    .rst         (rst),
    .inc         (sp_inc),
    .dec         (sp_dec),
    .sp          (sp),
    .stack_empty (stack_empty),
    .stack_full  (stack_full)
  );

  // Strobes are loaded on acceptance so they are high for the ISSUE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LOAD;
      dm_load    <= 1'b0;
      dm_store   <= 1'b0;
      dm_push    <= 1'b0;
      dm_pop     <= 1'b0;
      dm_address <= '0;
      dm_rez     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
    end else begin
      dm_load  <= 1'b0;
      dm_store <= 1'b0;
      dm_push  <= 1'b0;
      dm_pop   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= req_op_e;
            case (req_op_e)
              OP_LOAD: begin
                dm_load    <= 1'b1;
                dm_address <= req_addr;
                state      <= ISSUE;
              end
              OP_STORE: begin
                dm_store   <= 1'b1;
                dm_address <= req_addr;
                dm_rez     <= req_data;
                state      <= ISSUE;
              end
              OP_PUSH: begin
                if (stack_full) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  state     <= RESP;
                end else begin
                  dm_push <= 1'b1;
                  dm_rez  <= req_data;
                  state   <= ISSUE;
                end
              end
              OP_POP: begin
                if (stack_empty) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  state     <= RESP;
                end else begin
                  dm_pop <= 1'b1;
                  state  <= ISSUE;
                end
              end
            endcase
          end
        end
        ISSUE: begin
          if (op_q == OP_LOAD || op_q == OP_POP) begin
            state <= READ;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= RESP;
          end
        end
        READ: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= dm_data_out;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Randomized bench for stack_mem_ctrl against a queue/array reference model of the stack and memory.
module tb_stack_mem_ctrl;
  import stack_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [8:0]  req_addr;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        dm_load, dm_store, dm_push, dm_pop;
  logic [8:0]  dm_address;
  logic [15:0] dm_sp;
  logic [15:0] dm_rez;
  logic [15:0] dm_data_out;
  logic [15:0] sp;
  logic        stack_empty, stack_full;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stack_mem_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .dm_load     (dm_load),
    .dm_store    (dm_store),
    .dm_push     (dm_push),
    .dm_pop      (dm_pop),
    .dm_address  (dm_address),
    .dm_sp       (dm_sp),
    .dm_rez      (dm_rez),
    .dm_data_out (dm_data_out),
    .sp          (sp),
    .stack_empty (stack_empty),
    .stack_full  (stack_full)
  );

  // Behavioural data memory: one-cycle read latency, direct and stack regions kept apart.
  logic [15:0] dmem [0:511];
  logic [15:0] smem [0:65535];
  logic [15:0] rd_q = 16'h0;

  always @(posedge clk) begin
    if (dm_store) dmem[dm_address] <= dm_rez;
    if (dm_push)  smem[dm_sp]      <= dm_rez;
    if (dm_load)  rd_q <= dmem[dm_address];
    if (dm_pop)   rd_q <= smem[dm_sp];
  end
  assign dm_data_out = rd_q;

  // Reference model: stack contents as a queue, direct memory as an array.
  logic [15:0] stack_q [$];
  logic [15:0] mem_model [0:511];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] model_sp();
    return 16'(32'hFFFF - stack_q.size());
  endfunction

  // Holds reset across two falling edges and releases it on a falling edge.
  task automatic doReset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_addr = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stack_q.delete();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_strobes"}, {dm_load, dm_store, dm_push, dm_pop}, 4'b0000);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_sp"}, sp, model_sp());
    checkOutput({tag, "_dm_sp"}, dm_sp, model_sp());
    checkOutput({tag, "_empty"}, stack_empty, stack_q.size() == 0);
    checkOutput({tag, "_full"}, stack_full, stack_q.size() == 256);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] data);
    int          depth;
    bit          exp_err;
    int          exp_lat;
    logic [15:0] exp_rsp;
    logic [15:0] exp_dm_sp;
    logic [3:0]  exp_vec;
    bit          got_rsp;
    int          rsp_cycle;
    logic [15:0] got_data;
    logic        got_err;
    int          strobes_seen;
    int          strobe_cycle;
    logic [3:0]  strobe_vec;
    logic [15:0] seen_sp;
    logic [8:0]  seen_addr;
    logic [15:0] seen_rez;

    depth     = stack_q.size();
    exp_err   = (op == 2'd2 && depth == 256) || (op == 2'd3 && depth == 0);
    exp_lat   = exp_err ? 1 : ((op == 2'd0 || op == 2'd3) ? 3 : 2);
    exp_rsp   = 16'h0;
    if (!exp_err && op == 2'd0) exp_rsp = mem_model[addr];
    if (!exp_err && op == 2'd3) exp_rsp = stack_q[$];
    exp_dm_sp = 16'(32'hFFFF - depth + ((op == 2'd3) ? 1 : 0));
    exp_vec   = exp_err ? 4'b0000 : (4'b1000 >> op);

    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 2'($urandom);
    req_addr  = 9'($urandom);
    req_data  = 16'($urandom);

    got_rsp = 0; rsp_cycle = 0; got_data = '0; got_err = 1'b0;
    strobes_seen = 0; strobe_cycle = 0; strobe_vec = '0;
    seen_sp = '0; seen_addr = '0; seen_rez = '0;
    for (int cyc = 1; cyc <= 6 && !got_rsp; cyc++) begin
      @(negedge clk);
      checkOutput("req_ready_busy", req_ready, 0);
      if ((dm_load | dm_store | dm_push | dm_pop) == 1'b1) begin
        strobes_seen += int'(dm_load) + int'(dm_store) + int'(dm_push) + int'(dm_pop);
        strobe_cycle = cyc;
        strobe_vec   = {dm_load, dm_store, dm_push, dm_pop};
        seen_sp      = dm_sp;
        seen_addr    = dm_address;
        seen_rez     = dm_rez;
      end
      if (rsp_valid) begin
        got_rsp   = 1;
        rsp_cycle = cyc;
        got_data  = rsp_data;
        got_err   = rsp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    checkOutput("rsp_seen", got_rsp, 1);
    checkOutput("rsp_latency", rsp_cycle, exp_lat);
    checkOutput("rsp_err", got_err, exp_err);
    checkOutput("rsp_data", got_data, exp_rsp);
    checkOutput("strobe_count", strobes_seen, exp_err ? 0 : 1);
    checkOutput("strobe_kind", strobe_vec, exp_vec);
    if (!exp_err) begin
      checkOutput("strobe_cycle", strobe_cycle, 1);
      if (op == 2'd2 || op == 2'd3) checkOutput("strobe_dm_sp", seen_sp, exp_dm_sp);
      if (op == 2'd0 || op == 2'd1) checkOutput("strobe_dm_address", seen_addr, addr);
      if (op == 2'd1 || op == 2'd2) checkOutput("strobe_dm_rez", seen_rez, data);
    end

    if (!exp_err) begin
      case (op)
        2'd1: mem_model[addr] = data;
        2'd2: stack_q.push_back(data);
        2'd3: void'(stack_q.pop_back());
        default: ;
      endcase
    end

    @(negedge clk);
    checkIdle("post");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      dmem[i] = 16'h0;
      mem_model[i] = 16'h0;
    end
    for (int i = 0; i < 65536; i++) smem[i] = 16'h0;

    doReset();
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_dm_address", dm_address, 0);
    checkOutput("reset_dm_rez", dm_rez, 0);
    checkIdle("reset");

    // Directed scenarios.
    applyStimulus(2'd2, 9'h000, 16'hA5A5);
    applyStimulus(2'd3, 9'h000, 16'h0000);
    applyStimulus(2'd3, 9'h000, 16'h0000);
    applyStimulus(2'd2, 9'h000, 16'h1111);
    applyStimulus(2'd3, 9'h000, 16'h0000);
    applyStimulus(2'd1, 9'h1F0, 16'hBEEF);
    applyStimulus(2'd0, 9'h1F0, 16'h0000);

    // Fill the stack, then overflow it.
    for (int i = 0; i < 256; i++) applyStimulus(2'd2, 9'h000, 16'($urandom));
    checkOutput("fill_sp", sp, 16'hFEFF);
    checkOutput("fill_full", stack_full, 1);
    applyStimulus(2'd2, 9'h000, 16'h5A5A);

    // Randomized traffic starting from a full stack.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom), 9'h1F0 + 9'($urandom_range(0, 7)), 16'($urandom));
    end

    // Reset during ISSUE of a PUSH: the strobe must drop asynchronously.
    doReset();
    req_valid = 1'b1; req_op = 2'd2; req_addr = '0; req_data = 16'h2222;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("issue_push_strobe", dm_push, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_issue_strobe_drop", {dm_load, dm_store, dm_push, dm_pop}, 4'b0000);
    checkOutput("rst_issue_sp", sp, 16'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    stack_q.delete();

    // Reset during READ of a POP: response discarded, sp back to the top.
    applyStimulus(2'd2, 9'h000, 16'h1111);
    req_valid = 1'b1; req_op = 2'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("issue_pop_strobe", dm_pop, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_read_strobes", {dm_load, dm_store, dm_push, dm_pop}, 4'b0000);
    checkOutput("rst_read_rsp_valid", rsp_valid, 0);
    checkOutput("rst_read_sp", sp, 16'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    stack_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_read_no_rsp", rsp_valid, 0);
    end
    checkIdle("after_rst");
    applyStimulus(2'd3, 9'h000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
